pulse_seq_gen: RTL and testbench

- Parametrised, multi-channel successor to the single-output FIFO-driven pulse generator.
- Pops pulse-train commands from a show-ahead command FIFO and produces DELAY / WIDTH / GAP / COUNT shaped pulse trains.
- Each train is steered to one of NCH outputs.
- Single clock domain; sits between the command FIFO and the front-end strobe lines.

---
 rtl/pulse_seq_gen.sv | 179 +++++++++++++++++
 tb/tb_pulse_seq_gen.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_seq_gen.sv
// rtl/pulse_seq_gen.sv - multi-channel DELAY/WIDTH/GAP/COUNT pulse-train generator fed by a show-ahead command FIFO
// Optional macro PULSE_SEQ_DONE_CNT_EN adds the DONE_CNT completed-train counter output.
module pulse_seq_gen #(
  parameter int FIELD_W = 9,
  parameter int NCH     = 2,
  parameter int CH_W    = 1
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      ENABLE,
  input  logic                      ABORT,
  input  logic                      CMD_FIFO_EMPTY,
  input  logic [CH_W+4*FIELD_W-1:0] CMD_FIFO_Q,
  output logic                      CMD_FIFO_RD,
  output logic [NCH-1:0]            PULSE_OUT,
  output logic                      BUSY,
  output logic                      ERR_STB
`ifdef PULSE_SEQ_DONE_CNT_EN
  ,
  output logic [15:0]               DONE_CNT
`endif
);

  typedef enum logic [1:0] {IDLE, DLY, HIGH, LOW} state_t;

  localparam logic [FIELD_W-1:0] ONE = FIELD_W'(1);

  state_t             state_q, state_d;
  logic [FIELD_W-1:0] cnt_q, cnt_d;
  logic [FIELD_W-1:0] reps_q, reps_d;
  logic [FIELD_W-1:0] width_q, width_d;
  logic [FIELD_W-1:0] gap_q, gap_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [NCH-1:0]     pulse_q, pulse_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic [CH_W-1:0]    cmd_ch;
  logic [FIELD_W-1:0] cmd_delay, cmd_width, cmd_gap, cmd_count;
  logic               pop;
  logic               cmd_bad;
  logic [FIELD_W-1:0] gap_eff;

  assign {cmd_ch, cmd_delay, cmd_width, cmd_gap, cmd_count} = CMD_FIFO_Q;

  // The pop strobe is held low during reset even though the FSM already reads IDLE.
  assign pop     = RESET_N && (state_q == IDLE) && ENABLE && !CMD_FIFO_EMPTY && !ABORT;
  assign cmd_bad = (cmd_count == '0) || (cmd_width == '0) || (int'(cmd_ch) >= NCH);
  // A zero gap still produces one low cycle so adjacent pulses never merge.
  assign gap_eff = (gap_q == '0) ? ONE : gap_q;

  // Next-state, phase counter reload and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    reps_d  = reps_q;
    width_d = width_q;
    gap_d   = gap_q;
    ch_d    = ch_q;
    err_d   = 1'b0;
    if (ABORT) begin
      state_d = IDLE;
      cnt_d   = '0;
      reps_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            if (cmd_bad) begin
              err_d = 1'b1;
            end else begin
              width_d = cmd_width;
              gap_d   = cmd_gap;
              ch_d    = cmd_ch;
              reps_d  = cmd_count;
              if (cmd_delay != '0) begin
                state_d = DLY;
                cnt_d   = cmd_delay;
              end else begin
                state_d = HIGH;
                cnt_d   = cmd_width;
              end
            end
          end
        end
        DLY: begin
          if (cnt_q == ONE) begin
            state_d = HIGH;
            cnt_d   = width_q;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        HIGH: begin
          if (cnt_q == ONE) begin
            if (reps_q == ONE) begin
              state_d = IDLE;
              cnt_d   = '0;
              reps_d  = '0;
            end else begin
              state_d = LOW;
              reps_d  = reps_q - ONE;
              cnt_d   = gap_eff;
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        LOW: begin
          if (cnt_q == ONE) begin
            state_d = HIGH;
            cnt_d   = width_q;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
    for (int i = 0; i < NCH; i++) begin
      pulse_d[i] = (state_d == HIGH) && (int'(ch_d) == i);
    end
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      reps_q  <= '0;
      width_q <= '0;
      gap_q   <= '0;
      ch_q    <= '0;
      pulse_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reps_q  <= reps_d;
      width_q <= width_d;
      gap_q   <= gap_d;
      ch_q    <= ch_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign CMD_FIFO_RD = pop;
  assign PULSE_OUT   = pulse_q;
  assign BUSY        = busy_q;
  assign ERR_STB     = err_q;

`ifdef PULSE_SEQ_DONE_CNT_EN
  logic        last_high_done;
  logic [15:0] done_cnt_q, done_cnt_d;

  assign last_high_done = (state_q == HIGH) && (cnt_q == ONE) && (reps_q == ONE) && !ABORT;

  // Completed-train count; wraps naturally at 16 bits.
  always_comb begin
    done_cnt_d = done_cnt_q + (last_high_done ? 16'd1 : 16'd0);
  end

  // Completed-train counter register, cleared only by reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      done_cnt_q <= '0;
    end else begin
      done_cnt_q <= done_cnt_d;
    end
  end

  assign DONE_CNT = done_cnt_q;
`endif

endmodule

// File: tb/tb_pulse_seq_gen.sv
// tb/tb_pulse_seq_gen.sv - randomized and directed self-checking bench for pulse_seq_gen
module tb_pulse_seq_gen;

  localparam int FW  = 9;
  localparam int NCH = 2;
  localparam int CHW = 2;
  localparam int W   = CHW + 4*FW;

  logic           CLK;
  logic           RESET_N;
  logic           ENABLE;
  logic           ABORT;
  logic           fifo_empty;
  logic [W-1:0]   fifo_q;
  logic           CMD_FIFO_RD;
  logic [NCH-1:0] PULSE_OUT;
  logic           BUSY;
  logic           ERR_STB;
`ifdef PULSE_SEQ_DONE_CNT_EN
  logic [15:0]    DONE_CNT;
`endif

  pulse_seq_gen #(.FIELD_W(FW), .NCH(NCH), .CH_W(CHW)) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .ENABLE         (ENABLE),
    .ABORT          (ABORT),
    .CMD_FIFO_EMPTY (fifo_empty),
    .CMD_FIFO_Q     (fifo_q),
    .CMD_FIFO_RD    (CMD_FIFO_RD),
    .PULSE_OUT      (PULSE_OUT),
    .BUSY           (BUSY),
    .ERR_STB        (ERR_STB)
`ifdef PULSE_SEQ_DONE_CNT_EN
    ,
    .DONE_CNT       (DONE_CNT)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // ---------------- command FIFO environment ----------------
  logic [W-1:0] fifo[$];
  logic         rd_seen = 1'b0;

  function automatic void refresh();
    fifo_empty = (fifo.size() == 0);
    fifo_q     = fifo_empty ? '0 : fifo[0];
  endfunction

  function automatic logic [W-1:0] mk(input int ch, input int d, input int w, input int g, input int n);
    logic [W-1:0] r;
    r = {2'(ch), 9'(d), 9'(w), 9'(g), 9'(n)};
    return r;
  endfunction

  task automatic push(input logic [W-1:0] word);
    fifo.push_back(word);
    refresh();
  endtask

  always @(posedge CLK) begin
    #1;
    if (rd_seen && RESET_N && fifo.size() > 0) fifo.delete(0);
    rd_seen = 1'b0;
    refresh();
  end

  // ---------------- behavioural model ----------------
  logic [NCH-1:0] trq[$];
  logic [NCH-1:0] m_pulse = '0;
  logic           m_busy  = 1'b0;
  logic           m_err   = 1'b0;
  logic [15:0]    m_done  = '0;
  logic           exp_rd;
  logic [1:0]     c_ch;
  logic [8:0]     c_d, c_w, c_g, c_n;
  logic [NCH-1:0] oh;
  logic [NCH-1:0] prev_pulse = '0;
  int             cyc = 0;

  int n_rd, n_err, n_busy, n_rise, highs0, highs1, first_hi, rd_cyc, rd_first, last_busy;

  function automatic void clear_stats();
    n_rd = 0; n_err = 0; n_busy = 0; n_rise = 0; highs0 = 0; highs1 = 0;
    first_hi = -1; rd_cyc = -1; rd_first = -1; last_busy = -1;
  endfunction

  always @(negedge CLK) begin
    cyc++;
    if (!RESET_N) begin
      trq.delete();
      m_pulse = '0; m_busy = 1'b0; m_err = 1'b0; m_done = '0;
      rd_seen = 1'b0;
      chk("rst_pulse", PULSE_OUT, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_rd", CMD_FIFO_RD, 0);
      chk("rst_err", ERR_STB, 0);
    end else begin
      chk("pulse", PULSE_OUT, m_pulse);
      chk("busy", BUSY, m_busy);
      chk("err", ERR_STB, m_err);
`ifdef PULSE_SEQ_DONE_CNT_EN
      chk("done_cnt", DONE_CNT, m_done);
`endif
      exp_rd = !m_busy && ENABLE && !fifo_empty && !ABORT;
      chk("rd", CMD_FIFO_RD, exp_rd);
      rd_seen = CMD_FIFO_RD;
      if (CMD_FIFO_RD) begin
        if (n_rd == 0) rd_first = cyc;
        n_rd++;
        rd_cyc = cyc;
      end
      if (ERR_STB) n_err++;
      if (BUSY) begin n_busy++; last_busy = cyc; end
      highs0 += int'(PULSE_OUT[0]);
      highs1 += int'(PULSE_OUT[1]);
      if (PULSE_OUT != '0 && prev_pulse == '0) begin
        n_rise++;
        if (first_hi < 0) first_hi = cyc;
      end
      // advance the model to the next cycle
      m_err = 1'b0;
      if (m_busy && trq.size() == 0 && !ABORT) m_done = m_done + 16'd1;
      if (ABORT) begin
        trq.delete();
      end else if (exp_rd) begin
        {c_ch, c_d, c_w, c_g, c_n} = fifo_q;
        if (c_n == 0 || c_w == 0 || int'(c_ch) >= NCH) begin
          m_err = 1'b1;
        end else begin
          oh = '0;
          oh[c_ch[0]] = 1'b1;
          for (int i = 0; i < int'(c_d); i++) trq.push_back('0);
          for (int k = 0; k < int'(c_n); k++) begin
            for (int i = 0; i < int'(c_w); i++) trq.push_back(oh);
            if (k < int'(c_n) - 1)
              for (int i = 0; i < ((c_g == 0) ? 1 : int'(c_g)); i++) trq.push_back('0);
          end
        end
      end
      if (trq.size() > 0) begin
        m_pulse = trq.pop_front();
        m_busy  = 1'b1;
      end else begin
        m_pulse = '0;
        m_busy  = 1'b0;
      end
    end
    prev_pulse = PULSE_OUT;
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while ((m_busy || (fifo.size() > 0 && ENABLE && !ABORT)) && n < maxc);
    if (n >= maxc) chk("idle_timeout", 0, 1);
    step(2);
  endtask

  initial begin
    int n;
    RESET_N = 1'b0;
    ENABLE  = 1'b1;
    ABORT   = 1'b0;
    refresh();
    clear_stats();
    step(3);
    chk("reset_pulse", PULSE_OUT, 0);
    chk("reset_busy", BUSY, 0);
    chk("reset_err", ERR_STB, 0);
    RESET_N = 1'b1;
    step(2);

    // basic train
    clear_stats();
    push(mk(0, 0, 8, 0, 4));
    wait_idle(200);
    chk("basic_rd", n_rd, 1);
    chk("basic_busy", n_busy, 35);
    chk("basic_rises", n_rise, 4);
    chk("basic_highs0", highs0, 32);
    chk("basic_highs1", highs1, 0);
    chk("basic_latency", first_hi - rd_cyc, 1);

    // delay + channel
    clear_stats();
    push(mk(1, 384, 2, 3, 1));
    wait_idle(600);
    chk("dly_latency", first_hi - rd_cyc, 385);
    chk("dly_highs1", highs1, 2);
    chk("dly_highs0", highs0, 0);
    chk("dly_last_busy", last_busy - rd_cyc, 386);
`ifdef PULSE_SEQ_DONE_CNT_EN
    chk("dly_done_cnt", DONE_CNT, 2);
`endif

    // discards: COUNT=0, CH=2, WIDTH=0
    clear_stats();
    push(mk(0, 5, 3, 1, 0));
    push(mk(2, 0, 3, 0, 2));
    push(mk(1, 0, 0, 0, 2));
    wait_idle(50);
    chk("disc_rd", n_rd, 3);
    chk("disc_err", n_err, 3);
    chk("disc_busy", n_busy, 0);
    chk("disc_highs", highs0 + highs1, 0);

    // back-to-back with ENABLE gating
    clear_stats();
    push(mk(0, 2, 3, 1, 2));
    push(mk(1, 0, 2, 0, 3));
    step(4);
    ENABLE = 1'b0;
    step(30);
    chk("b2b_rd_gated", n_rd, 1);
    chk("b2b_idle", BUSY, 0);
    ENABLE = 1'b1;
    wait_idle(100);
    chk("b2b_rd", n_rd, 2);
    chk("b2b_highs0", highs0, 6);
    chk("b2b_highs1", highs1, 6);
    clear_stats();
    push(mk(0, 0, 2, 0, 1));
    push(mk(1, 0, 2, 0, 1));
    wait_idle(50);
    chk("b2b_pop_spacing", rd_cyc - rd_first, 3);

    // abort during 2nd HIGH
    clear_stats();
    push(mk(0, 0, 4, 2, 4));
    n = 0;
    while (n_rise < 2 && n < 50) begin step(1); n++; end
    chk("abort_reach", n_rise, 2);
    ABORT = 1'b1;
    step(1);
    ABORT = 1'b0;
    chk("abort_busy_next", BUSY, 0);
    chk("abort_pulse_next", PULSE_OUT, 0);
    wait_idle(50);
    chk("abort_highs0", highs0, 6);
    chk("abort_busy", n_busy, 8);

    // abort in IDLE is a no-op and blocks pops
    clear_stats();
    ABORT = 1'b1;
    push(mk(0, 0, 1, 0, 1));
    step(3);
    chk("abort_idle_rd", n_rd, 0);
    ABORT = 1'b0;
    wait_idle(50);
    chk("abort_idle_rd2", n_rd, 1);
    chk("abort_idle_highs", highs0, 1);

    // full-scale fields
    clear_stats();
    push(mk(1, 511, 511, 511, 2));
    wait_idle(3000);
    chk("full_latency", first_hi - rd_cyc, 512);
    chk("full_highs1", highs1, 1022);
    chk("full_busy", n_busy, 2044);

    // randomized traffic
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 2) != 0)
        push(mk($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 3), $urandom_range(0, 3)));
      ENABLE = ($urandom_range(0, 3) != 0);
      ABORT  = ($urandom_range(0, 9) == 0);
      step($urandom_range(1, 6));
      ABORT  = 1'b0;
    end
    ENABLE = 1'b1;
    ABORT  = 1'b0;
    wait_idle(3000);
    chk("rand_drained", fifo.size(), 0);

    // async reset mid-HIGH
    clear_stats();
    push(mk(1, 3, 20, 0, 2));
    n = 0;
    while (highs1 == 0 && n < 50) begin step(1); n++; end
    @(posedge CLK);
    #3;
    RESET_N = 1'b0;
    #1;
    chk("areset_pulse", PULSE_OUT, 0);
    chk("areset_busy", BUSY, 0);
    chk("areset_rd", CMD_FIFO_RD, 0);
    step(2);
    RESET_N = 1'b1;
    step(5);
    chk("areset_no_replay", BUSY, 0);

    // async reset mid-DLY
    push(mk(0, 50, 2, 0, 1));
    n = 0;
    while (!m_busy && n < 20) begin step(1); n++; end
    step(3);
    #1;
    RESET_N = 1'b0;
    #1;
    chk("dreset_busy", BUSY, 0);
    chk("dreset_pulse", PULSE_OUT, 0);
    step(2);
    RESET_N = 1'b1;
    step(5);
    chk("dreset_idle", BUSY, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
